// File: rtl/product_bcd_display_if.sv
// Product hand-off between the multiplier (master) and the BCD display block (slave).
interface product_bcd_display_if;
  logic [7:0]  prod_in;
  logic        prod_valid;
  logic        busy;
  logic [11:0] bcd;
  logic        bcd_valid;

  modport master (output prod_in, prod_valid, input busy, bcd, bcd_valid);
  modport slave  (input prod_in, prod_valid, output busy, bcd, bcd_valid);
endinterface

// File: rtl/product_bcd_display.sv
// Captures an 8-bit product, converts it to 3-digit BCD by sequential double-dabble,
// and scans it onto a 4-digit multiplexed seven-segment display with leading-zero blanking.
module product_bcd_display #(
  parameter int REFRESH_BITS   = 17,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                       clkin,
  input  logic                       reset,
  product_bcd_display_if.slave       bus,
  output logic [6:0]                 seg,
  output logic [3:0]                 an,
  output logic                       dp
);

  typedef enum logic {IDLE, CONV} state_e;

  state_e                  state_q, state_d;
  logic                    prev_valid_q;
  logic [7:0]              bin_q, bin_d;
  logic [11:0]             scratch_q, scratch_d;
  logic [11:0]             bcd_q, bcd_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    bcd_valid_q, bcd_valid_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic                    start;
  logic [11:0]             adj;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    bcd_valid_d = 1'b0;
    scan_d      = scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    start       = bus.prod_valid & ~prev_valid_q;

    adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bus.prod_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d              = cnt_q + 3'd1;
        // Eighth shift completes the conversion; a start seen this cycle is dropped.
        if (cnt_q == 3'd7) begin
          bcd_d       = scratch_d;
          bcd_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      bin_q        <= '0;
      scratch_q    <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      bcd_valid_q  <= 1'b0;
      scan_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= bus.prod_valid;
      bin_q        <= bin_d;
      scratch_q    <= scratch_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      bcd_valid_q  <= bcd_valid_d;
      scan_q       <= scan_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1111110;
      4'd1:    seg_encode = 7'b0110000;
      4'd2:    seg_encode = 7'b1101101;
      4'd3:    seg_encode = 7'b1111001;
      4'd4:    seg_encode = 7'b0110011;
      4'd5:    seg_encode = 7'b1011011;
      4'd6:    seg_encode = 7'b1011111;
      4'd7:    seg_encode = 7'b1110000;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1111011;
      default: seg_encode = 7'b0000000;
    endcase
  endfunction

  logic [1:0] sel;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_hi;
  logic [3:0] an_hi;

  // Display reads only the committed bcd register, never the in-flight scratch.
  always_comb begin
    sel   = scan_q[REFRESH_BITS-1 -: 2];
    digit = 4'd0;
    blank = 1'b1;
    case (sel)
      2'd0: begin digit = bcd_q[3:0];  blank = 1'b0; end
      2'd1: begin digit = bcd_q[7:4];  blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0); end
      2'd2: begin digit = bcd_q[11:8]; blank = (bcd_q[11:8] == 4'd0); end
      default: blank = 1'b1;
    endcase
    seg_hi = blank ? 7'b0000000 : seg_encode(digit);
    an_hi  = 4'b0001 << sel;
    seg    = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an     = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
    dp     = SEG_ACTIVE_LOW ? 1'b1    : 1'b0;
  end

endmodule

// File: tb/tb_product_bcd_display.sv
// Scoreboard bench: stimulus pushes expected BCD results, a monitor pops them on bcd_valid.
module tb_product_bcd_display;
  logic clk = 1'b0;
  logic reset;
  logic [6:0] seg_lo, seg_hi;
  logic [3:0] an_lo, an_hi;
  logic dp_lo, dp_hi;
  logic [3:0] tb_scan;
  int errors = 0;
  int checks = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  product_bcd_display_if bus_lo ();
  product_bcd_display_if bus_hi ();
  assign bus_hi.prod_in    = bus_lo.prod_in;
  assign bus_hi.prod_valid = bus_lo.prod_valid;

  product_bcd_display #(.REFRESH_BITS(4), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clkin(clk), .reset(reset), .bus(bus_lo), .seg(seg_lo), .an(an_lo), .dp(dp_lo));
  product_bcd_display #(.REFRESH_BITS(4), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clkin(clk), .reset(reset), .bus(bus_hi), .seg(seg_hi), .an(an_hi), .dp(dp_hi));

  always @(posedge clk) tb_scan <= reset ? 4'd0 : tb_scan + 4'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_lo.bcd_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_bcd_valid", {20'd0, bus_lo.bcd}, 32'hFFFF_FFFF);
      else check("scoreboard_bcd", {20'd0, bus_lo.bcd}, {20'd0, sb.pop_front()});
    end
  end

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input logic [1:0] s);
    logic [3:0] d;
    logic blank;
    logic [6:0] tbl [10];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    case (s)
      2'd0: begin d = b[3:0];  blank = 1'b0; end
      2'd1: begin d = b[7:4];  blank = (b[11:8] == 0) && (b[7:4] == 0); end
      2'd2: begin d = b[11:8]; blank = (b[11:8] == 0); end
      default: begin d = 4'd0; blank = 1'b1; end
    endcase
    exp_seg = blank ? 7'b0000000 : tbl[d];
  endfunction

  task automatic display_check(input logic [11:0] b);
    logic [6:0] es;
    logic [3:0] ea;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      es = exp_seg(b, tb_scan[3:2]);
      ea = 4'b0001 << tb_scan[3:2];
      check("seg_active_high", {25'd0, seg_hi}, {25'd0, es});
      check("an_active_high",  {28'd0, an_hi},  {28'd0, ea});
      check("seg_active_low",  {25'd0, seg_lo}, {25'd0, ~es});
      check("an_active_low",   {28'd0, an_lo},  {28'd0, ~ea});
      check("dp_off", {30'd0, dp_lo, dp_hi}, 32'd2);
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp);
    @(negedge clk);
    bus_lo.prod_in = v;
    bus_lo.prod_valid = 1'b1;
    sb.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_lo.prod_valid = 1'b0;
      check("busy_during_conv", {31'd0, bus_lo.busy}, 32'd1);
    end
    @(negedge clk);
    check("busy_after_conv", {31'd0, bus_lo.busy}, 32'd0);
    check("bcd_valid_latency", {31'd0, bus_lo.bcd_valid}, 32'd1);
    check("bcd_value", {20'd0, bus_lo.bcd}, {20'd0, exp});
    @(negedge clk);
    check("bcd_valid_one_cycle", {31'd0, bus_lo.bcd_valid}, 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    bus_lo.prod_in = 8'h00;
    bus_lo.prod_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, bus_lo.busy}, 32'd0);
    check("reset_bcd", {20'd0, bus_lo.bcd}, 32'h000);
    check("reset_bcd_valid", {31'd0, bus_lo.bcd_valid}, 32'd0);
    reset = 1'b0;
    display_check(12'h000);

    convert(8'hE1, 12'h225);
    convert(8'hFF, 12'h255);
    convert(8'h00, 12'h000);
    convert(8'h09, 12'h009);
    display_check(12'h009);

    // Reset lands on the 4th CONV edge: conversion aborts, nothing is pushed.
    @(negedge clk);
    bus_lo.prod_in = 8'hC8;
    bus_lo.prod_valid = 1'b1;
    @(negedge clk);
    bus_lo.prod_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, bus_lo.busy}, 32'd0);
    check("abort_bcd", {20'd0, bus_lo.bcd}, 32'h000);
    check("abort_bcd_valid", {31'd0, bus_lo.bcd_valid}, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_stays_idle", {31'd0, bus_lo.busy}, 32'd0);
    convert(8'h80, 12'h128);

    // Second edge three cycles into CONV is ignored.
    pulses = 0;
    @(negedge clk);
    bus_lo.prod_in = 8'h63;
    bus_lo.prod_valid = 1'b1;
    sb.push_back(12'h099);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus_lo.bcd_valid) pulses++;
      bus_lo.prod_valid = (i == 2);
      if (i == 2) bus_lo.prod_in = 8'h11;
    end
    check("dropped_edge_pulses", pulses, 1);
    check("dropped_edge_bcd", {20'd0, bus_lo.bcd}, 32'h099);

    // Level held for 20 cycles starts exactly one conversion.
    pulses = 0;
    @(negedge clk);
    bus_lo.prod_in = 8'h2A;
    bus_lo.prod_valid = 1'b1;
    sb.push_back(12'h042);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_lo.bcd_valid) pulses++;
      if (i == 19) bus_lo.prod_valid = 1'b0;
    end
    check("held_level_pulses", pulses, 1);
    check("held_level_bcd", {20'd0, bus_hi.bcd}, 32'h042);
    display_check(12'h042);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
